// File: rtl/foo_pipe_arbiter.sv
// Round-robin sharing of one fixed-latency foo pipeline among NUM_REQ requesters; result returns LATENCY+1 cycles after grant, in issue order.
// Backpressure: grants stop while in-flight plus buffered results reach RESP_DEPTH, so the unstallable pipeline never loses a result.

// Pointer-based response FIFO; head visible the cycle after push.
// Simultaneous push/pop is legal at any occupancy; overflow is a caller bug and is asserted.
module foo_pipe_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  output logic             pop_vld,
  input  logic             pop_rdy,
  output logic [WIDTH-1:0] pop_dat
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             pop;
  logic             full;

  assign pop_vld = (count_q != '0);
  assign full    = (count_q == CW'(DEPTH));
  assign pop     = pop_vld & pop_rdy;
  assign pop_dat = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(push_vld) - CW'(pop);
    if (push_vld) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push_vld && full && !pop));
endmodule

// Arbiter, issue and tag tracking around the shared pipeline.
// Grant is combinational from req_valid and registered credit only; never depends on resp_ready.
module foo_pipe_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_W     = 32,
  parameter int LATENCY    = 3,
  parameter int RESP_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [DATA_W-1:0]           pipe_x,
  output logic                        pipe_input_valid,
  input  logic [DATA_W-1:0]           pipe_out,
  output logic                        resp_valid,
  input  logic                        resp_ready,
  output logic [$clog2(NUM_REQ)-1:0]  resp_id,
  output logic [DATA_W-1:0]           resp_data,
  output logic                        busy
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int OW  = $clog2(RESP_DEPTH + 1);

  typedef struct packed {
    logic [IDW-1:0]    id;
    logic [DATA_W-1:0] dat;
  } resp_t;

  logic [IDW-1:0]              last_grant_q, last_grant_d;
  logic [OW-1:0]               outstanding_q, outstanding_d;
  logic [LATENCY-1:0]          tag_vld_q, tag_vld_d;
  logic [LATENCY-1:0][IDW-1:0] tag_id_q, tag_id_d;

  logic [DATA_W-1:0] req_arr [NUM_REQ];
  logic [IDW-1:0]    grant_id;
  logic [IDW-1:0]    cand;
  logic              found;
  logic              credit;
  logic              xfer;
  logic              pop;
  resp_t             push_dat;
  resp_t             head;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_arr[g] = req_data[g*DATA_W +: DATA_W];
  end

  assign credit = (outstanding_q < OW'(RESP_DEPTH));

  // Search from the requester after the last winner, wrapping at NUM_REQ.
  always_comb begin
    found    = 1'b0;
    grant_id = '0;
    cand     = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = IDW'((int'(last_grant_q) + off) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found    = 1'b1;
        grant_id = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (found && credit && !rst) req_ready[grant_id] = 1'b1;
  end

  assign xfer             = |(req_valid & req_ready);
  assign pipe_input_valid = xfer;
  assign pipe_x           = xfer ? req_arr[grant_id] : '0;

  always_comb begin
    tag_vld_d    = tag_vld_q;
    tag_id_d     = tag_id_q;
    tag_vld_d[0] = xfer;
    tag_id_d[0]  = grant_id;
    for (int s = 1; s < LATENCY; s++) begin
      tag_vld_d[s] = tag_vld_q[s-1];
      tag_id_d[s]  = tag_id_q[s-1];
    end
  end

  assign push_dat = '{id: tag_id_q[LATENCY-1], dat: pipe_out};
  assign pop      = resp_valid & resp_ready;

  // A push only moves an entry from in-flight to buffered, so credit ignores it.
  always_comb begin
    last_grant_d  = xfer ? grant_id : last_grant_q;
    outstanding_d = outstanding_q + OW'(xfer) - OW'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q  <= IDW'(NUM_REQ - 1);
      outstanding_q <= '0;
      tag_vld_q     <= '0;
      tag_id_q      <= '0;
    end else begin
      last_grant_q  <= last_grant_d;
      outstanding_q <= outstanding_d;
      tag_vld_q     <= tag_vld_d;
      tag_id_q      <= tag_id_d;
    end
  end

  foo_pipe_fifo #(
    .WIDTH ($bits(resp_t)),
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_vld (tag_vld_q[LATENCY-1]),
    .push_dat (push_dat),
    .pop_vld  (resp_valid),
    .pop_rdy  (resp_ready),
    .pop_dat  (head)
  );

  assign resp_id   = head.id;
  assign resp_data = head.dat;
  assign busy      = (outstanding_q != '0);
endmodule

// File: doc/foo_pipe_arbiter.md
# foo_pipe_arbiter

Round-robin arbiter and sequencer that shares one instance of the 3-stage `foo` pipeline (result = x + 3 mod 2^32, fixed latency, no stall) among NUM_REQ requesters. It tags each issued operand with its requester ID and tracks tags alongside the pipeline. Results are collected into a response FIFO and returned on a single valid/ready port. Credit-based issue guarantees no result is ever dropped, because the pipeline cannot be back-pressured.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (≥2)
- DATA_W, 32, operand/result width
- LATENCY, 3, edges from issue edge to result-capture edge of the shared pipeline
- RESP_DEPTH, 8, response FIFO entries; must be ≥ LATENCY+2 for one issue per cycle

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset; also drives the pipeline's rst
- req_valid  in  NUM_REQ  per-requester operand valid
- req_data  in  NUM_REQ*DATA_W  requester i operand in bits [i*DATA_W +: DATA_W]
- req_ready  out  NUM_REQ  one-hot grant; transfer when req_valid[i] & req_ready[i]
- pipe_x  out  DATA_W  operand to the pipeline `x`
- pipe_input_valid  out  1  to the pipeline `input_valid`
- pipe_out  in  DATA_W  pipeline `out`
- resp_valid  out  1  FIFO head valid
- resp_ready  in  1  consumer accepts head
- resp_id  out  clog2(NUM_REQ)  requester ID of the head result
- resp_data  out  DATA_W  head result
- busy  out  1  any operation in flight or buffered

## Operation
- **Credit:** `outstanding` counts in-flight tags plus FIFO occupancy. Issue is allowed iff `outstanding < RESP_DEPTH`, using the registered value. There is no same-cycle pop bypass.
- **Arbitration:** combinational round-robin over req_valid. Search starts at `last_grant + 1` and wraps at NUM_REQ.
  - At most one req_ready bit is high, and only when credit is available.
  - last_grant updates only on a transfer. It resets to NUM_REQ-1, so requester 0 has first priority.
- **Issue:** pipe_x = req_data of the granted requester; pipe_input_valid = transfer. When no transfer occurs, pipe_x holds 0.
- **Tag pipe:** LATENCY-entry shift register of {valid, id}. Stage 0 loads {transfer, grant_id} at each edge. The last stage marks the cycle in which pipe_out carries that operation's result.
- **Capture:** when the last tag stage is valid, push {id, pipe_out} into the FIFO at that edge.
- **FIFO:** RESP_DEPTH entries, pointer-based, with wrap-around.
  - resp_valid = not empty.
  - Pop on resp_valid & resp_ready.
  - Simultaneous push and pop is legal at any occupancy, including full-with-pop.
  - Push while full without a pop is impossible by the credit rule; flag it with an assertion.
- **outstanding update:** +1 on issue, −1 on pop, unchanged on simultaneous issue and pop. A push does not change it; the entry only moves from in-flight to FIFO.
- **busy** = (outstanding != 0).
- **Reset (asynchronous):** applies at any time, including mid-operation.
  - Clears tag valids, FIFO pointers and storage, outstanding and last_grant.
  - In-flight operations are discarded.
  - While rst is high, req_ready and pipe_input_valid are forced to 0.

## Timing
- Reset values: req_ready 0, pipe_x 0, pipe_input_valid 0, resp_valid 0, resp_id 0, resp_data 0, busy 0.
- Issue latency: a request presented in cycle c with credit available is granted combinationally in cycle c.
- Result latency: the result is pushed at the end of cycle c+LATENCY, and resp_valid is high from cycle c+LATENCY+1. Issue-to-response is LATENCY+1 cycles.
- Throughput: one issue per cycle when resp_ready is held high and RESP_DEPTH ≥ LATENCY+2.
- Ordering: responses leave in issue order.
- Stability: req_ready depends combinationally on req_valid and registered state only, not on resp_ready.

## Test plan
- **Single request:** reset, then req_valid=4'b0001 with operand 0x0000_0005 in cycle 0. Required: req_ready=4'b0001 in cycle 0; resp_valid in cycle 4 with id 0, data 0x0000_0008; busy returns to 0 after the pop.
- **Round-robin fairness:** all four requesters valid continuously with operands 0x10·i, resp_ready=1. Required: grants 0,1,2,3,0,… one per cycle; responses (0,0x3),(1,0x13),(2,0x23),(3,0x33) in order with no gaps.
- **Wrap-around arithmetic:** requester 2 issues 0xFFFF_FFFE. Required: resp_id 2, resp_data 0x0000_0001.
- **Back-pressure and credit:** resp_ready=0, all requesters valid. Required: exactly 8 issues, then req_ready=0 while the FIFO holds 8 entries and pipe_input_valid stays 0. Raising resp_ready for 1 cycle frees 1 credit, so exactly one new issue occurs one cycle later.
- **Reset mid-flight:** issue 3 operations, assert rst asynchronously after 2 cycles. Required: resp_valid and busy go to 0 immediately, no stale response is ever presented, and requester 0 has first priority after release.
